// File: rtl/output_drain_pkg.sv
// Shared types for the output drain FIFO: beat layout,
// occupancy states and the occupancy-width helper.
package output_drain_pkg;

    localparam int ODF_DATA_W  = 32;
    localparam int ODF_COORD_W = 32;

    typedef struct packed {
        logic [ODF_DATA_W-1:0]  data;
        logic [ODF_COORD_W-1:0] x;
        logic [ODF_COORD_W-1:0] y;
        logic [ODF_COORD_W-1:0] ch;
    } output_beat_t;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_state_t;

    // Counter must hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int OCC_WIDTH = occ_width(8);

endpackage

// File: rtl/output_fifo_mem.sv
// Storage array for the drain FIFO: one write port, async read.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o.
module output_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; validity lives in the top.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/output_drain_fifo.sv
// Output drain FIFO: captures controller beats, drains them to the
// host over valid/ready, raises early stall and sticky overflow.
// Ports: clk, arst_n_in, start, in_* (beat), out_* (host side),
// stall, overflow, occupancy, beat_count.
// Build option: OUTPUT_DRAIN_STATS_EN enables the beat counter.
module output_drain_fifo
    import output_drain_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int COORD_WIDTH        = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [COORD_WIDTH-1:0]        in_x,
    input  logic [COORD_WIDTH-1:0]        in_y,
    input  logic [COORD_WIDTH-1:0]        in_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [COORD_WIDTH-1:0]        out_x,
    output logic [COORD_WIDTH-1:0]        out_y,
    output logic [COORD_WIDTH-1:0]        out_ch,
    output logic                          stall,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [31:0]                   beat_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = occ_width(FIFO_DEPTH);
    localparam logic [OW-1:0] DEPTH_C  = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] STALL_AT =
        OW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

    occ_state_t    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          stall_q, stall_d;
    logic          ovf_q, ovf_d;
    logic          full, push, pop, drop;
    output_beat_t  wr_beat, rd_beat, head;

    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    assign wr_beat = '{data: in_data, x: in_x, y: in_y, ch: in_ch};

    output_fifo_mem #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(output_beat_t))
    ) u_mem (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(wr_beat),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_beat)
    );

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (occ_d == '0) begin
            state_d = EMPTY;
        end else if (occ_d == DEPTH_C) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        // Registered from next occupancy so stall never glitches.
        stall_d = (occ_d >= STALL_AT);

        // A drop in the same cycle as start must still be recorded.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (start) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        full      = 1'b0;
        case (state_q)
            EMPTY:   out_valid = 1'b0;
            PARTIAL: out_valid = 1'b1;
            FULL: begin
                out_valid = 1'b1;
                full      = 1'b1;
            end
            default: out_valid = 1'b0;
        endcase
    end

    // Mask stale storage so the host sees zeros when nothing is valid.
    assign head      = out_valid ? rd_beat : '0;
    assign out_data  = head.data;
    assign out_x     = head.x;
    assign out_y     = head.y;
    assign out_ch    = head.ch;
    assign stall     = stall_q;
    assign overflow  = ovf_q;
    assign occupancy = occ_q;

`ifdef OUTPUT_DRAIN_STATS_EN
    logic [31:0] bc_q, bc_d;

    always_comb begin
        bc_d = start ? {31'b0, push} : bc_q + {31'b0, push};
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            bc_q <= '0;
        end else begin
            bc_q <= bc_d;
        end
    end

    assign beat_count = bc_q;
`else
    assign beat_count = '0;
`endif

endmodule

// File: tb/tb_output_drain_fifo.sv
// Scoreboard bench for output_drain_fifo.
// Honours OUTPUT_DRAIN_STATS_EN for the beat_count expectation.
module tb_output_drain_fifo;
    import output_drain_pkg::*;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data, in_x, in_y, in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data, out_x, out_y, out_ch;
    logic        stall;
    logic        overflow;
    logic [3:0]  occupancy;
    logic [31:0] beat_count;

    int n_chk  = 0;
    int n_pass = 0;

    output_beat_t sb[$];
    logic         movf;
    logic [31:0]  mbc;

    always #5 clk = ~clk;

    output_drain_fifo #(
        .DATA_WIDTH(32),
        .COORD_WIDTH(32),
        .FIFO_DEPTH(DEPTH),
        .ALMOST_FULL_MARGIN(MARGIN)
    ) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_ch    (out_ch),
        .stall     (stall),
        .overflow  (overflow),
        .occupancy (occupancy),
        .beat_count(beat_count)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_bc();
`ifdef OUTPUT_DRAIN_STATS_EN
        return mbc;
`else
        return 32'd0;
`endif
    endfunction

    // Called in the low clock phase with inputs already driven.
    task automatic step();
        logic         pop_m, push_m, drop_m;
        output_beat_t e;
        #1;
        pop_m = (sb.size() != 0) && out_ready;
        check("out_valid", out_valid, sb.size() != 0);
        if (pop_m) begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_x", out_x, e.x);
            check("out_y", out_y, e.y);
            check("out_ch", out_ch, e.ch);
        end
        push_m = in_valid && (sb.size() < DEPTH || pop_m);
        drop_m = in_valid && !push_m;
        if (push_m) begin
            sb.push_back('{data: in_data, x: in_x,
                           y: in_y, ch: in_ch});
        end
        movf = drop_m ? 1'b1 : (start ? 1'b0 : movf);
        mbc  = start ? {31'b0, push_m} : mbc + {31'b0, push_m};
        @(posedge clk);
        #1;
        check("occupancy", occupancy, sb.size());
        check("stall", stall, sb.size() >= DEPTH - MARGIN);
        check("overflow", overflow, movf);
        check("beat_count", beat_count, exp_bc());
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_x     = x;
        in_y     = y;
        in_ch    = c;
        step();
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        check(tag, sb.size(), 0);
        step();
    endtask

    initial begin
        arst_n_in = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_x      = '0;
        in_y      = '0;
        in_ch     = '0;
        out_ready = 1'b0;
        movf      = 1'b0;
        mbc       = '0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall, 0);
        check("rst_ovf", overflow, 0);
        check("rst_bc", beat_count, 0);
        repeat (2) @(negedge clk);
        arst_n_in = 1'b1;

        // Single beat straight through.
        out_ready = 1'b1;
        send(32'hA5, 32'd3, 32'd1, 32'd2);
        check("t1_latency", out_valid, 1);
        idle(5);

        // Fill to FULL with the host stalled.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), 32'(i + 10), 32'(i + 20), 32'(i + 30));
            idle(5);
        end
        check("full_occ", occupancy, DEPTH);
        check("full_stall", stall, 1);
        send(32'h99, 32'h9, 32'h9, 32'h9);
        check("ovf_set", overflow, 1);
        check("head_kept", out_data, 1);

        // start clears overflow/stats only.
        start = 1'b1;
        step();
        check("start_ovf", overflow, 0);
        check("start_occ", occupancy, DEPTH);

        // Simultaneous push and pop while FULL.
        out_ready = 1'b1;
        send(32'h100, 32'h1, 32'h2, 32'h3);
        check("pp_occ", occupancy, DEPTH);
        check("pp_ovf", overflow, 0);
        drain("drain_full");

        // Pointer wrap with alternating ready.
        for (int i = 0; i < 20; i++) begin
            out_ready = i[0];
            send(32'h200 + 32'(i), 32'(i), 32'(2 * i), 32'(3 * i));
            out_ready = ~i[0];
            step();
        end
        drain("drain_wrap");

        // Asynchronous reset with 5 entries held.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h300 + 32'(i), 0, 0, 0);
        check("pre_rst_occ", occupancy, 5);
        arst_n_in = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_occ", occupancy, 0);
        check("arst_bc", beat_count, 0);
        sb.delete();
        movf = 1'b0;
        mbc  = '0;
        @(negedge clk);
        arst_n_in = 1'b1;
        out_ready = 1'b1;
        send(32'h400, 32'd7, 32'd8, 32'd9);
        check("post_rst_valid", out_valid, 1);
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/output_drain_fifo.md
# output_drain_fifo

Output stage directly downstream of the convolution controller/datapath. It captures each completed output beat, meaning the ODS result plus its (x, y, ch) coordinates, on the controller's single-cycle `output_valid` pulse. Beats go into a small first-word-fall-through FIFO and drain to the external host over a valid/ready handshake. The controller has no backpressure input, so the block raises an early `stall` flag for the top level to gate `start`/`con_ready`. It also records any beat lost to overflow.

## Interface
- `DATA_WIDTH`, 32: width of one output result.
- `COORD_WIDTH`, 32: width of each of x, y, ch.
- `FIFO_DEPTH`, 8: entries; power of two, ≥4.
- `ALMOST_FULL_MARGIN`, 2: `stall` asserts when free entries ≤ this value.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `arst_n_in`  in  1  asynchronous reset, active low.
- `start`  in  1  pulse; clears `overflow` and `beat_count` (FIFO contents untouched).
- `in_valid`  in  1  one-cycle beat strobe from controller (`output_valid`).
- `in_data`  in  DATA_WIDTH  result value.
- `in_x`, `in_y`, `in_ch`  in  COORD_WIDTH each  beat coordinates.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  host accepts head entry.
- `out_data`  out  DATA_WIDTH  head result.
- `out_x`, `out_y`, `out_ch`  out  COORD_WIDTH each  head coordinates.
- `stall`  out  1  almost-full indication to top level.
- `overflow`  out  1  sticky: a beat was dropped.
- `occupancy`  out  $clog2(FIFO_DEPTH)+1  current entry count.
- `beat_count`  out  32  accepted beats since reset/`start` (see Configuration).

## Operation
- Push happens when `in_valid && (!full || pop)`, where `pop = out_valid && out_ready`.
- Pop happens when `out_valid && out_ready`.
- Occupancy FSM:
  - EMPTY (occ 0): `out_valid`=0.
  - PARTIAL (0<occ<DEPTH).
  - FULL (occ DEPTH).
  - Transitions are driven only by the push/pop net change (+1, −1, 0).
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo DEPTH. Occupancy is held in a separate counter; full and empty are never derived from pointer equality alone.
- Push while FULL with no simultaneous pop: the beat is dropped, `overflow` sets the next cycle, and occupancy and pointers are unchanged.
- Push and pop together in FULL: both are performed and occupancy stays DEPTH.
- Push and pop together in PARTIAL: occupancy is unchanged and the head advances.
- Pop in EMPTY is impossible because `out_valid`=0; `out_ready` is ignored.
- `stall` = `occupancy >= FIFO_DEPTH - ALMOST_FULL_MARGIN`, registered from next-state occupancy so that it is glitch-free.
- `overflow` clears only on reset or `start`. If `start` and a drop occur in the same cycle, the drop wins and `overflow`=1.
- Outputs `out_*` are stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data`/`out_x`/`out_y`/`out_ch`=0, `stall`=0, `overflow`=0, `occupancy`=0, `beat_count`=0, pointers 0.
- Latency: a beat pushed into an empty FIFO at edge N is visible (`out_valid`=1) after edge N, i.e. in the cycle after the `in_valid` pulse.
- Throughput is one push and one pop per cycle. The controller produces at most one beat per 6 cycles.
- Reset mid-operation discards all contents immediately and asynchronously. `out_valid` drops without waiting for an edge.
- Overflow drop is silent toward the host; the host observes no handshake change.

## Configuration
- `OUTPUT_DRAIN_STATS_EN`:
  - Defined: `beat_count` increments by 1 on every accepted push and wraps at 2^32. It clears on `start`; if push and `start` coincide, the result is 1.
  - Undefined: the counter logic is not compiled and `beat_count` is tied to 0.
- FIFO behaviour is identical in both builds.

## Structure
- Shared package `output_drain_pkg`:
  - packed struct `output_beat_t` {data, x, y, ch}.
  - localparam `OCC_WIDTH` helper.
  - occupancy-state enum {EMPTY, PARTIAL, FULL}.
- Sub-module `output_fifo_mem`: DEPTH×`$bits(output_beat_t)` register array with one write port and an asynchronous read port at the read pointer. It has no reset on storage; only the output registers and flags reset.
- The top keeps the pointers, occupancy FSM, flags and stats.

## Test plan
- Reset, then single beat (data=0xA5, x=3, y=1, ch=2) with `out_ready`=1 → `out_valid` one cycle later carrying the same values; occupancy returns to 0.
- `out_ready`=0, 8 beats at 6-cycle spacing → occupancy 8, `stall`=1 from occupancy 6, FULL. A 9th beat → `overflow`=1 and data unchanged. The drain then yields beats 1..8 in order.
- FULL and `out_ready`=1 with `in_valid` in the same cycle → occupancy stays 8, no overflow, the new beat appears last.
- Wrap-around: 20 beats with alternating `out_ready` → output sequence equals input sequence across pointer wrap, with no loss.
- `start` pulse after overflow → `overflow`=0 and `beat_count`=0 (STATS_EN), FIFO contents still drained intact. Repeat without the macro → `beat_count` is always 0.
- `arst_n_in` low while occupancy is 5 → `out_valid`=0 and occupancy=0 immediately. After release, the next beat is accepted normally.
